// File: rtl/isa_shared.sv
// Shared RV32 decode definitions: immediate format encodings and the raw
// 32-bit immediate builder used by the decode stage and sign_ext.
package isa_shared;

  // Immediate format select. Code 3'd7 is reserved and is not an enumerator.
  typedef enum logic [2:0] {
    IMM_3120  = 3'd0,  // I-type: inst[31:20]
    IMM_S     = 3'd1,  // S-type: inst[31:25], inst[11:7]
    IMM_B     = 3'd2,  // B-type branch offset
    IMM_U     = 3'd3,  // U-type upper immediate
    IMM_J     = 3'd4,  // J-type jump offset
    IMM_SHAMT = 3'd5,  // shift amount inst[24:20], zero-extended
    IMM_ZIMM  = 3'd6   // CSR uimm inst[19:15], zero-extended
  } imm_op_e;

  localparam logic [2:0] IMM_RSVD = 3'd7;

  localparam int unsigned INST_FIELD_W = 25;  // carries inst[31:7]
  localparam int unsigned IMM32_W      = 32;

  // True when the select code has no defined immediate format.
  function automatic logic imm_op_is_rsvd(input logic [2:0] op);
    return (op == IMM_RSVD);
  endfunction

  // Builds the 32-bit immediate from instruction bits [31:7]. Signed formats
  // are already sign-extended to bit 31, so widening beyond 32 bits only has
  // to replicate bit 31. Zero-extended formats and the reserved code leave
  // bit 31 clear, so the same widening rule holds for them too.
  function automatic logic [IMM32_W-1:0] build_imm32(
    input logic [INST_FIELD_W-1:0] instr,
    input logic [2:0]              op
  );
    logic                s;
    logic [IMM32_W-1:0]  imm;
    s   = instr[24];
    imm = '0;
    case (op)
      IMM_3120:  imm = {{20{s}}, instr[24:13]};
      IMM_S:     imm = {{20{s}}, instr[24:18], instr[4:0]};
      IMM_B:     imm = {{19{s}}, instr[24], instr[0], instr[23:18], instr[4:1], 1'b0};
      IMM_U:     imm = {instr[24:5], 12'b0};
      IMM_J:     imm = {{11{s}}, instr[24], instr[12:5], instr[13], instr[23:14], 1'b0};
      IMM_SHAMT: imm = {27'b0, instr[17:13]};
      IMM_ZIMM:  imm = {27'b0, instr[12:8]};
      default:   imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/sign_ext.sv
// RV32 immediate generator: combinational extended immediate for operand
// muxing plus a registered copy for the next pipeline stage.
// DATA_WIDTH must be at least 32.
module sign_ext
  import isa_shared::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [INST_FIELD_W-1:0] instruction,
  input  logic [2:0]              imm_op,
  output logic [DATA_WIDTH-1:0]   sign_extended_data,
  output logic [DATA_WIDTH-1:0]   sign_extended_data_q,
  output logic                    imm_op_invalid
);

  logic [IMM32_W-1:0] imm32;

  // Select and extend the immediate; zero latency, independent of clk/rst.
  always_comb begin
    imm32              = build_imm32(instruction, imm_op);
    sign_extended_data = DATA_WIDTH'($signed(imm32));
    imm_op_invalid     = imm_op_is_rsvd(imm_op);
  end

  // Pipeline register; reset wins over the load enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_extended_data_q <= '0;
    end else if (en) begin
      sign_extended_data_q <= sign_extended_data;
    end
  end

endmodule

// File: tb/tb_sign_ext.sv
module tb_sign_ext;
  import isa_shared::*;

  logic        clk;
  logic        rst;
  logic        en;
  logic [24:0] instruction;
  logic [2:0]  imm_op;
  logic [31:0] sign_extended_data;
  logic [31:0] sign_extended_data_q;
  logic        imm_op_invalid;

  int passed;
  int total;

  sign_ext #(.DATA_WIDTH(32)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .en                   (en),
    .instruction          (instruction),
    .imm_op               (imm_op),
    .sign_extended_data   (sign_extended_data),
    .sign_extended_data_q (sign_extended_data_q),
    .imm_op_invalid       (imm_op_invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive_inst(input logic [31:0] inst, input logic [2:0] op);
    instruction = inst[31:7];
    imm_op      = op;
    #1;
  endtask

  initial begin
    logic [24:0] r;
    logic [31:0] exp;
    passed      = 0;
    total       = 0;
    rst         = 1'b0;
    en          = 1'b0;
    instruction = '0;
    imm_op      = IMM_3120;

    // Reset: one edge with rst high clears the register.
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_q", sign_extended_data_q, 32'h0);
    rst = 1'b0;

    // I-type, random vectors.
    imm_op = IMM_3120;
    for (int i = 0; i < 1000; i++) begin
      r           = 25'($urandom);
      instruction = r;
      #1;
      exp = {{20{r[24]}}, r[24:13]};
      check("i_random", sign_extended_data, exp);
    end

    instruction = 25'b000000000000_10101_010_10101;
    #1;
    check("i_zero_field", sign_extended_data, 32'h00000000);
    check("i_valid_flag", {31'b0, imm_op_invalid}, 32'h0);

    instruction = {12'h800, 13'($urandom)};
    #1;
    check("i_most_neg", sign_extended_data, 32'hFFFFF800);

    instruction = {12'h7FF, 13'($urandom)};
    #1;
    check("i_most_pos", sign_extended_data, 32'h000007FF);

    // Other formats from concrete encodings.
    drive_inst(32'hFE000FE3, IMM_B);
    check("b_minus2", sign_extended_data, 32'hFFFFFFFE);
    check("b_valid_flag", {31'b0, imm_op_invalid}, 32'h0);

    drive_inst(32'h800000EF, IMM_J);
    check("j_most_neg", sign_extended_data, 32'hFFF00000);

    drive_inst(32'h123450B7, IMM_U);
    check("u_lui", sign_extended_data, 32'h12345000);

    drive_inst(32'hFE112E23, IMM_S);
    check("s_minus4", sign_extended_data, 32'hFFFFFFFC);

    // Zero-extended formats ignore instruction[24].
    instruction = 25'h1_03E000;  // [24]=1, [17:13]=5'b11111
    imm_op      = IMM_SHAMT;
    #1;
    check("shamt_no_sext", sign_extended_data, 32'h0000001F);

    instruction = 25'h1_001500;  // [24]=1, [12:8]=5'h15
    imm_op      = IMM_ZIMM;
    #1;
    check("zimm", sign_extended_data, 32'h00000015);
    check("zimm_valid_flag", {31'b0, imm_op_invalid}, 32'h0);

    // Reserved code.
    instruction = 25'h1FF_FFFF;
    imm_op      = 3'd7;
    #1;
    check("rsvd_zero", sign_extended_data, 32'h0);
    check("rsvd_flag", {31'b0, imm_op_invalid}, 32'h1);

    // Register path: load.
    instruction = {12'hFFF, 13'h0};
    imm_op      = IMM_3120;
    en          = 1'b1;
    @(posedge clk);
    #1;
    check("q_load", sign_extended_data_q, 32'hFFFFFFFF);

    // Hold while disabled, even though the combinational value changes.
    en          = 1'b0;
    instruction = {12'h123, 13'h0};
    #1;
    check("comb_changed", sign_extended_data, 32'h00000123);
    @(posedge clk);
    #1;
    check("q_hold", sign_extended_data_q, 32'hFFFFFFFF);
    @(posedge clk);
    #1;
    check("q_hold2", sign_extended_data_q, 32'hFFFFFFFF);

    // Reset has priority over enable.
    instruction = {12'hFFF, 13'h0};
    rst         = 1'b1;
    en          = 1'b1;
    @(posedge clk);
    #1;
    check("q_rst_over_en", sign_extended_data_q, 32'h0);
    check("comb_during_rst", sign_extended_data, 32'hFFFFFFFF);

    // Load resumes after reset deasserts.
    rst         = 1'b0;
    instruction = {12'h001, 13'h0};
    @(posedge clk);
    #1;
    check("q_load_after_rst", sign_extended_data_q, 32'h00000001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
